alsu_cmd_issuer: RTL and testbench
==================================

# alsu_cmd_issuer

Command sequencer directly upstream of the ALSU. It accepts packed ALSU command words over a valid/ready handshake and buffers them in a small FIFO. It replays each command onto the ALSU's per-field input pins for one or more consecutive cycles, so shift and rotate operations chain without software pacing. When no command is pending, it drives a NOP pattern (all zeros).

## Interface
Parameters:
- DEPTH, 4, FIFO depth in commands; power of two, 2..16. LW = $clog2(DEPTH)+1.

Ports:
- clk  in  1  single clock; one clock domain; all logic on posedge
- rst  in  1  reset; asynchronous and active-low
- cmd_valid  in  1  upstream command valid
- cmd_ready  out  1  FIFO can accept; `!full`, forced 0 while rst is low
- cmd  in  19  alsu_cmd_t packed {repeat[2:0], opcode[2:0], A[2:0], B[2:0], cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction}
- A, B  out  3 each  signed operands to ALSU
- opcode  out  3  ALSU opcode
- cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction  out  1 each  ALSU control bits
- busy  out  1  a command is currently being driven
- level  out  LW  FIFO occupancy
- drop_cnt  out  8  count of rejected commands; saturates at 255

## Operation
- Push: the FIFO is written at a posedge when cmd_valid && cmd_ready.
- Full behaviour: cmd_ready is 0 when full. There is no write-through when full, even if a pop occurs in the same cycle.
- FSM states:
  - IDLE: no command is driven; outputs hold NOP (all zero).
  - ACTIVE: the head command is driven and the remaining-cycle counter rem[2:0] is valid.
- Pop (IDLE, or ACTIVE with rem==0, and FIFO non-empty):
  - Outputs are loaded from the head command and the FSM goes to ACTIVE.
  - rem is loaded with `repeat` if opcode is 4 or 5 (shift/rotate); otherwise rem = 0 and `repeat` is ignored.
- ACTIVE with rem>0: outputs are held unchanged and rem decrements.
- ACTIVE with rem==0 and FIFO empty: outputs go to NOP and the FSM goes to IDLE.
- Result: a command occupies exactly repeat+1 consecutive output cycles (shift/rotate) or 1 cycle (all others). Back-to-back commands have no bubble.
- Simultaneous push and pop on a non-full FIFO: both occur and level is unchanged.
- busy = (state == ACTIVE).
- Reset (rst low, at any time including mid-command): FIFO is emptied, level=0, state=IDLE, rem=0, all ALSU-side outputs=0, busy=0, drop_cnt=0. Any in-flight command is discarded. Operation resumes from an empty FIFO.

## Timing
- Command accepted at edge t, FIFO previously empty and FSM IDLE: fields appear on ALSU outputs after edge t+1. The ALSU registers them at edge t+2.
- All ALSU-side outputs, busy and level are registered. cmd_ready is combinational from full and rst only.
- level updates at the push/pop edge.
- drop_cnt updates at the edge where the rejected word is presented with cmd_valid && cmd_ready.

## Configuration
- Macro: ALSU_CMD_PRECHECK_EN.
- Defined: at push, a word is rejected when bypass_A==0 && bypass_B==0 && ((red_op_A|red_op_B) && (opcode[1]|opcode[2]) || opcode[2:1]==2'b11).
  - A rejected word is handshaken (cmd_ready honoured) but not written.
  - drop_cnt increments, saturating at 255.
- Undefined: all words are written unchanged. drop_cnt is tied to 0. The ALSU handles invalid cases itself.

## Structure
- Shared package alsu_pkg contains:
  - typedef alsu_cmd_t (packed struct above)
  - localparams OP_OR=0, OP_XOR=1, OP_ADD=2, OP_MUL=3, OP_SHIFT=4, OP_ROT=5
  - function is_invalid(alsu_cmd_t), used by this block and reusable by the ALSU bench
- Sub-module alsu_cmd_fifo: synchronous FIFO with parameter DEPTH and a width equal to $bits(alsu_cmd_t). It has push, pop, full, empty and level ports and an asynchronous active-low reset. alsu_cmd_issuer instantiates it once.

## Test plan
- Reset → cmd_ready=0 while rst low; after release: cmd_ready=1, level=0, all outputs 0, busy=0.
- Push OR (A=3'b011, B=3'b100, op=0, repeat=5) at edge t → op=0, A=3, B=-4 driven for exactly 1 cycle after edge t+1, then NOP; busy high for 1 cycle.
- Push SHIFT (op=4, direction=1, serial_in=1, repeat=3) followed immediately by ADD (A=2, B=1, cin=1) → SHIFT fields held 4 cycles, ADD driven the next cycle with no gap, then NOP.
- Hold cmd_valid=1 with 6 words while the FSM is held in a long rotate (repeat=7) with DEPTH=4 → cmd_ready falls after 4 accepted words (plus the one in flight); level=4; no word lost or duplicated in output order.
- With ALSU_CMD_PRECHECK_EN: push {op=2, red_op_A=1, no bypass} and {op=6, bypass_A=1} → first dropped (drop_cnt=1, level unchanged), second issued; 300 invalid pushes → drop_cnt=255.
- Assert rst at the 2nd cycle of a repeat=5 shift with 2 words queued → outputs 0 and level=0 asynchronously; after release only newly pushed commands appear.

Source files
------------

// File: rtl/alsu_pkg.sv
// rtl/alsu_pkg.sv - shared ALSU command types, opcodes and the invalid-command predicate
package alsu_pkg;

    typedef struct packed {
        logic [2:0]        rpt;
        logic [2:0]        opcode;
        logic signed [2:0] A;
        logic signed [2:0] B;
        logic              cin;
        logic              serial_in;
        logic              red_op_A;
        logic              red_op_B;
        logic              bypass_A;
        logic              bypass_B;
        logic              direction;
    } alsu_cmd_t;

    // Pin-side view of a command: everything except the repeat count.
    typedef struct packed {
        logic [2:0]        opcode;
        logic signed [2:0] A;
        logic signed [2:0] B;
        logic              cin;
        logic              serial_in;
        logic              red_op_A;
        logic              red_op_B;
        logic              bypass_A;
        logic              bypass_B;
        logic              direction;
    } alsu_pins_t;

    localparam logic [2:0] OP_OR    = 3'd0;
    localparam logic [2:0] OP_XOR   = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_MUL   = 3'd3;
    localparam logic [2:0] OP_SHIFT = 3'd4;
    localparam logic [2:0] OP_ROT   = 3'd5;

    function automatic logic is_invalid(input alsu_cmd_t c);
        return !c.bypass_A && !c.bypass_B &&
               (((c.red_op_A | c.red_op_B) && (c.opcode[1] | c.opcode[2])) ||
                (c.opcode[2:1] == 2'b11));
    endfunction

    function automatic logic is_chained(input logic [2:0] op);
        return (op == OP_SHIFT) || (op == OP_ROT);
    endfunction

    function automatic alsu_pins_t to_pins(input alsu_cmd_t c);
        return alsu_pins_t'(c[$bits(alsu_pins_t)-1:0]);
    endfunction

endpackage

// File: rtl/alsu_cmd_issuer_if.sv
// rtl/alsu_cmd_issuer_if.sv - upstream command valid/ready channel into the issuer
interface alsu_cmd_issuer_if;
    import alsu_pkg::*;

    logic      cmd_valid;
    logic      cmd_ready;
    alsu_cmd_t cmd;

    modport master (output cmd_valid, output cmd, input cmd_ready);
    modport slave  (input cmd_valid, input cmd, output cmd_ready);
endinterface

// File: rtl/alsu_cmd_fifo.sv
// rtl/alsu_cmd_fifo.sv - synchronous command FIFO, power-of-two depth, async active-low reset
module alsu_cmd_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 19,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign dout    = mem[rd_ptr];
    // No write-through when full: a same-cycle pop does not make room.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/alsu_cmd_issuer.sv
// rtl/alsu_cmd_issuer.sv - buffers ALSU commands and replays them onto the ALSU pins (repeat for shift/rotate)
// Optional ALSU_CMD_PRECHECK_EN: drop invalid command words at push and count them in drop_cnt.
module alsu_cmd_issuer
    import alsu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    alsu_cmd_issuer_if.slave    cmd_if,
    output logic signed [2:0]   A,
    output logic signed [2:0]   B,
    output logic [2:0]          opcode,
    output logic                cin,
    output logic                serial_in,
    output logic                red_op_A,
    output logic                red_op_B,
    output logic                bypass_A,
    output logic                bypass_B,
    output logic                direction,
    output logic                busy,
    output logic [LW-1:0]       level,
    output logic [7:0]          drop_cnt
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t     state, state_n;
    logic [2:0] rem, rem_n;
    alsu_pins_t pins_q, pins_n;

    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       fifo_push;
    logic                       fifo_pop;
    logic [$bits(alsu_cmd_t)-1:0] fifo_dout;
    alsu_cmd_t                  head;
    logic                       accept;

    assign cmd_if.cmd_ready = rst && !fifo_full;
    assign accept           = cmd_if.cmd_valid && cmd_if.cmd_ready;
    assign head             = alsu_cmd_t'(fifo_dout);

`ifdef ALSU_CMD_PRECHECK_EN
    logic reject;

    assign reject    = is_invalid(cmd_if.cmd);
    assign fifo_push = accept && !reject;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt <= 8'd0;
        end else if (accept && reject && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`else
    assign fifo_push = accept;
    assign drop_cnt  = 8'd0;
`endif

    alsu_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(alsu_cmd_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (cmd_if.cmd),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            rem    <= 3'd0;
            pins_q <= '0;
        end else begin
            state  <= state_n;
            rem    <= rem_n;
            pins_q <= pins_n;
        end
    end

    // The next head is popped on the last replay cycle, so chained commands have no bubble.
    always_comb begin
        state_n  = state;
        rem_n    = rem;
        pins_n   = pins_q;
        fifo_pop = 1'b0;
        if ((state == ACTIVE) && (rem != 3'd0)) begin
            rem_n = rem - 3'd1;
        end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
            pins_n   = to_pins(head);
            rem_n    = is_chained(head.opcode) ? head.rpt : 3'd0;
            state_n  = ACTIVE;
        end else begin
            pins_n  = '0;
            rem_n   = 3'd0;
            state_n = IDLE;
        end
    end

    assign opcode    = pins_q.opcode;
    assign A         = pins_q.A;
    assign B         = pins_q.B;
    assign cin       = pins_q.cin;
    assign serial_in = pins_q.serial_in;
    assign red_op_A  = pins_q.red_op_A;
    assign red_op_B  = pins_q.red_op_B;
    assign bypass_A  = pins_q.bypass_A;
    assign bypass_B  = pins_q.bypass_B;
    assign direction = pins_q.direction;
    assign busy      = (state == ACTIVE);

endmodule

// File: tb/tb_alsu_cmd_issuer.sv
// tb/tb_alsu_cmd_issuer.sv - self-checking bench for alsu_cmd_issuer
module tb_alsu_cmd_issuer;
    import alsu_pkg::*;

    localparam int DEPTH = 4;
    localparam int LW    = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    alsu_cmd_issuer_if cmd_if ();

    logic signed [2:0] A, B;
    logic [2:0]        opcode;
    logic              cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction;
    logic              busy;
    logic [LW-1:0]     level;
    logic [7:0]        drop_cnt;

    alsu_cmd_issuer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_if    (cmd_if),
        .A         (A),
        .B         (B),
        .opcode    (opcode),
        .cin       (cin),
        .serial_in (serial_in),
        .red_op_A  (red_op_A),
        .red_op_B  (red_op_B),
        .bypass_A  (bypass_A),
        .bypass_B  (bypass_B),
        .direction (direction),
        .busy      (busy),
        .level     (level),
        .drop_cnt  (drop_cnt)
    );

    alsu_cmd_t out_word;
    assign out_word = {3'b000, opcode, A, B, cin, serial_in, red_op_A, red_op_B,
                       bypass_A, bypass_B, direction};

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic alsu_cmd_t mk(input int rpt, input int op, input int a, input int b,
                                     input int ci, input int ser, input int ra, input int rb,
                                     input int ba, input int bb, input int dir);
        alsu_cmd_t c;
        c.rpt = rpt[2:0]; c.opcode = op[2:0]; c.A = a[2:0]; c.B = b[2:0];
        c.cin = ci[0]; c.serial_in = ser[0]; c.red_op_A = ra[0]; c.red_op_B = rb[0];
        c.bypass_A = ba[0]; c.bypass_B = bb[0]; c.direction = dir[0];
        return c;
    endfunction

    function automatic alsu_cmd_t strip(input alsu_cmd_t c);
        alsu_cmd_t s;
        s     = c;
        s.rpt = 3'd0;
        return s;
    endfunction

    alsu_cmd_t obs[$];
    bit        mon_en = 1'b0;
    always @(negedge clk) if (mon_en && busy) obs.push_back(out_word);

    // Entered and left at posedge+1.
    task automatic push_word(input alsu_cmd_t c);
        bit r;
        bit done;
        done = 1'b0;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd       = c;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            r = cmd_if.cmd_ready;
            @(posedge clk);
            if (r) done = 1'b1;
        end
        #1;
        cmd_if.cmd_valid = 1'b0;
        if (!done) chk("push_timeout", 0, 1);
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (!busy && level == '0) ok = 1'b1;
        end
        chk(name, int'(ok), 1);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        alsu_cmd_t c;
        int        cycles;
    } vec_t;

    vec_t      vecs [8];
    alsu_cmd_t words [7];
    alsu_cmd_t exp_q [$];
    alsu_cmd_t c_sh, c_add, c_new, c_bad, c_good;
    int        idx, first_block, max_level;
    bit        r;

    initial begin
        vecs[0] = '{mk(5, 0, 3, 4, 0, 0, 0, 0, 0, 0, 0), 1};
        vecs[1] = '{mk(7, 1, 5, 6, 1, 0, 0, 0, 0, 0, 1), 1};
        vecs[2] = '{mk(3, 4, 1, 2, 0, 1, 0, 0, 0, 0, 1), 4};
        vecs[3] = '{mk(0, 5, 7, 1, 0, 0, 0, 0, 0, 0, 0), 1};
        vecs[4] = '{mk(2, 5, 2, 5, 0, 1, 0, 0, 0, 0, 0), 3};
        vecs[5] = '{mk(2, 3, 6, 3, 1, 0, 0, 0, 0, 0, 0), 1};
        vecs[6] = '{mk(4, 6, 2, 3, 0, 0, 0, 0, 1, 0, 0), 1};
        vecs[7] = '{mk(1, 7, 4, 4, 0, 0, 0, 1, 0, 1, 1), 1};

        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd       = '0;

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready_low", int'(cmd_if.cmd_ready), 0);
        chk("rst_word", int'(out_word), 0);
        chk("rst_busy", int'(busy), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rel_ready", int'(cmd_if.cmd_ready), 1);
        chk("rel_level", int'(level), 0);
        chk("rel_word", int'(out_word), 0);
        chk("rel_busy", int'(busy), 0);
        chk("rel_drop", int'(drop_cnt), 0);
        @(posedge clk);
        #1;

        // Single commands into an idle issuer
        for (int i = 0; i < 8; i++) begin
            push_word(vecs[i].c);
            @(negedge clk);
            chk($sformatf("v%0d_lat_busy", i), int'(busy), 0);
            chk($sformatf("v%0d_lat_level", i), int'(level), 1);
            for (int k = 0; k < vecs[i].cycles; k++) begin
                @(negedge clk);
                chk($sformatf("v%0d_word_c%0d", i, k), int'(out_word), int'(strip(vecs[i].c)));
                chk($sformatf("v%0d_busy_c%0d", i, k), int'(busy), 1);
                if (i == 0 && k == 0) begin
                    chk("or_A_signed", int'(A), 3);
                    chk("or_B_signed", int'(B), -4);
                end
            end
            @(negedge clk);
            chk($sformatf("v%0d_nop", i), int'(out_word), 0);
            chk($sformatf("v%0d_idle", i), int'(busy), 0);
            @(posedge clk);
            #1;
        end

        // SHIFT repeat=3 then ADD, back to back
        c_sh  = mk(3, 4, 1, 1, 0, 1, 0, 0, 0, 0, 1);
        c_add = mk(0, 2, 2, 1, 1, 0, 0, 0, 0, 0, 0);
        push_word(c_sh);
        push_word(c_add);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("b2b_shift_c%0d", k), int'(out_word), int'(strip(c_sh)));
        end
        @(negedge clk);
        chk("b2b_add", int'(out_word), int'(strip(c_add)));
        chk("b2b_add_busy", int'(busy), 1);
        @(negedge clk);
        chk("b2b_nop", int'(out_word), 0);
        @(posedge clk);
        #1;

        // Long rotate while valid is held with six more words
        words[0] = mk(7, 5, 3, 2, 0, 1, 0, 0, 0, 0, 1);
        for (int k = 1; k < 7; k++) words[k] = mk(0, 0, k, 7 - k, 0, 0, 0, 0, 0, 0, 0);
        obs.delete();
        mon_en           = 1'b1;
        idx              = 0;
        first_block      = -1;
        max_level        = 0;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd       = words[0];
        for (int cyc = 0; cyc < 200 && idx < 7; cyc++) begin
            @(negedge clk);
            r = cmd_if.cmd_ready;
            if (int'(level) > max_level) max_level = int'(level);
            if (!r && first_block < 0) first_block = idx;
            @(posedge clk);
            if (r) idx++;
            #1;
            if (idx < 7) cmd_if.cmd = words[idx];
        end
        cmd_if.cmd_valid = 1'b0;
        chk("full_all_accepted", idx, 7);
        chk("full_first_block", first_block, 5);
        chk("full_max_level", max_level, 4);
        wait_idle("full_drain");
        mon_en = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 8; k++) exp_q.push_back(strip(words[0]));
        for (int k = 1; k < 7; k++) exp_q.push_back(strip(words[k]));
        chk("full_obs_len", obs.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < obs.size(); k++)
            chk($sformatf("full_obs_%0d", k), int'(obs[k]), int'(exp_q[k]));

        // Reset in the middle of a repeat=5 shift with two words queued
        push_word(mk(5, 4, 6, 1, 0, 1, 0, 0, 0, 0, 0));
        push_word(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        push_word(mk(0, 2, 2, 2, 0, 0, 0, 0, 0, 0, 0));
        chk("mid_busy", int'(busy), 1);
        chk("mid_level", int'(level), 2);
        #2 rst = 1'b0;
        #1;
        chk("arst_word", int'(out_word), 0);
        chk("arst_level", int'(level), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_ready", int'(cmd_if.cmd_ready), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        obs.delete();
        mon_en = 1'b1;
        c_new  = mk(0, 1, 5, 3, 1, 0, 0, 0, 0, 0, 1);
        push_word(c_new);
        wait_idle("post_rst_drain");
        mon_en = 1'b0;
        chk("post_rst_len", obs.size(), 1);
        if (obs.size() > 0) chk("post_rst_word", int'(obs[0]), int'(strip(c_new)));

        // Invalid-word handling
        c_bad  = mk(0, 2, 1, 1, 0, 0, 1, 0, 0, 0, 0);
        c_good = mk(0, 6, 2, 3, 0, 0, 0, 0, 1, 0, 0);
`ifdef ALSU_CMD_PRECHECK_EN
        push_word(c_bad);
        @(negedge clk);
        chk("drop_cnt_1", int'(drop_cnt), 1);
        chk("drop_level", int'(level), 0);
        @(negedge clk);
        chk("drop_not_issued", int'(busy), 0);
        @(posedge clk);
        #1;
        push_word(c_good);
        @(negedge clk);
        chk("good_level", int'(level), 1);
        @(negedge clk);
        chk("good_issued", int'(out_word), int'(strip(c_good)));
        @(negedge clk);
        chk("good_nop", int'(out_word), 0);
        @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd       = c_bad;
        repeat (300) @(posedge clk);
        #1 cmd_if.cmd_valid = 1'b0;
        @(negedge clk);
        chk("drop_saturate", int'(drop_cnt), 255);
        chk("drop_sat_level", int'(level), 0);
`else
        push_word(c_bad);
        @(negedge clk);
        chk("pass_level", int'(level), 1);
        @(negedge clk);
        chk("pass_issued", int'(out_word), int'(strip(c_bad)));
        chk("pass_drop_zero", int'(drop_cnt), 0);
`endif
        @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
